cache_mem_responder: RTL and testbench

//  Memory-side responder for the cache's refill/writeback port: accepts rd_req/wr_req, serves them

---
 rtl/cache_mem_responder_if.sv | 33 +++
 rtl/cache_mem_responder.sv | 130 +++++++++++++
 tb/tb_cache_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Refill/writeback port between the cache (master) and the memory responder (slave).
// Carries the read request, the beat return channel and the line/word write channel.
interface cache_mem_responder_if #(
   parameter int LINE_W = 128
);
   logic              rd_req;
   logic [2:0]        rd_type;
   logic [31:0]       rd_addr;
   logic              rd_rdy;
   logic              ret_valid;
   logic              ret_last;
   logic [31:0]       ret_data;
   logic              wr_req;
   logic [2:0]        wr_type;
   logic [31:0]       wr_addr;
   logic [3:0]        wr_wstrb;
   logic [LINE_W-1:0] wr_data;
   logic              wr_rdy;

   modport master (
      output rd_req, rd_type, rd_addr,
      input  rd_rdy, ret_valid, ret_last, ret_data,
      output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  wr_rdy
   );

   modport slave (
      input  rd_req, rd_type, rd_addr,
      output rd_rdy, ret_valid, ret_last, ret_data,
      input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output wr_rdy
   );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder under the cache: word-addressed array, 4-beat line reads, single-beat words.
// Optional macro CACHE_RSP_STALL_EN adds LFSR-driven rdy gating and beat bubbles.
module cache_mem_responder #(
   parameter int MEM_AW = 12,
   parameter int RD_LAT = 2,
   parameter int LINE_W = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   cache_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST} state_t;

   localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

   state_t            state, state_nxt;
   logic [3:0]        lat_cnt, lat_nxt;
   logic [1:0]        beat_cnt, beat_nxt;
   logic              rd_line;
   logic [MEM_AW-1:0] rd_idx;
   logic [31:0]       mem [0:(1<<MEM_AW)-1];

   logic              rdy_gate, beat_en;
   logic              rd_rdy_c, ret_valid_c, ret_last_c;
   logic              rd_accept, wr_fire, beat_last;
   logic [MEM_AW-1:0] beat_idx, wr_idx;
   logic [31:0]       wr_lane;
   logic              ret_valid;
   logic              unused_addr;

`ifdef CACHE_RSP_STALL_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign rdy_gate = lfsr[0];
   assign beat_en  = lfsr[1];
`else
   assign rdy_gate = 1'b1;
   assign beat_en  = 1'b1;
`endif

   assign beat_idx  = rd_line ? {rd_idx[MEM_AW-1:2], beat_cnt} : rd_idx;
   assign beat_last = !rd_line || (beat_cnt == 2'd3);

   always_comb begin
      state_nxt   = state;
      lat_nxt     = lat_cnt;
      beat_nxt    = beat_cnt;
      rd_rdy_c    = 1'b0;
      ret_valid_c = 1'b0;
      ret_last_c  = 1'b0;
      rd_accept   = 1'b0;
      case (state)
         IDLE: begin
            rd_rdy_c = rdy_gate;
            if (bus.rd_req && rdy_gate && !reset) begin
               rd_accept = 1'b1;
               lat_nxt   = LAT_INIT;
               beat_nxt  = 2'd0;
               state_nxt = (RD_LAT == 1) ? RD_BURST : RD_WAIT;
            end
         end
         RD_WAIT: begin
            lat_nxt = lat_cnt - 4'd1;
            if (lat_cnt <= 4'd1) state_nxt = RD_BURST;
         end
         RD_BURST: begin
            // A stall bubble holds the current beat; order and data are unaffected
            if (beat_en) begin
               ret_valid_c = 1'b1;
               ret_last_c  = beat_last;
               if (beat_last) state_nxt = IDLE;
               else           beat_nxt  = beat_cnt + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         lat_cnt  <= lat_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_accept) begin
         rd_idx  <= bus.rd_addr[MEM_AW+1:2];
         rd_line <= (bus.rd_type == 3'b100);
      end
   end

   assign wr_fire = bus.wr_req && rdy_gate && !reset;
   assign wr_idx  = bus.wr_addr[MEM_AW+1:2];
   assign wr_lane = bus.wr_data[{bus.wr_addr[3:2], 5'b0} +: 32];

   // Write commits at the accepting edge, so a beat in the same cycle still sees the old word
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         if (bus.wr_type == 3'b100) begin
            for (int i = 0; i < LINE_W / 32; i++)
               mem[{wr_idx[MEM_AW-1:2], 2'(i)}] <= bus.wr_data[32*i +: 32];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bus.wr_wstrb[b]) mem[wr_idx][8*b +: 8] <= wr_lane[8*b +: 8];
         end
      end
   end

   assign ret_valid     = ret_valid_c && !reset;
   assign bus.ret_valid = ret_valid;
   assign bus.ret_last  = ret_last_c && !reset;
   assign bus.ret_data  = ret_valid ? mem[beat_idx] : 32'd0;
   assign bus.rd_rdy    = rd_rdy_c && !reset;
   assign bus.wr_rdy    = rdy_gate && !reset;

   assign unused_addr = ^{bus.rd_addr[31:MEM_AW+2], bus.rd_addr[1:0],
                          bus.wr_addr[31:MEM_AW+2], bus.wr_addr[1:0]};
endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: per-cycle behavioural model with directed and random traffic.
// Builds with or without CACHE_RSP_STALL_EN.
module tb_cache_mem_responder;
   localparam int MEM_AW = 12;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 1 << MEM_AW;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cache_mem_responder_if #(.LINE_W(128)) bus ();

   cache_mem_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .LINE_W(128)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Model state: memory image, pending beat addresses of the open read, latency countdown
   logic [31:0] mm [DEPTH];
   bit          known [DEPTH];
   int          beat_q[$];
   int          busy = 0, wait_c = 0, cyc = 0, acc_cyc = 0, lat_meas = 0;
   int          last_seen = 0, last_exp = 0;
   logic [31:0] obs_q[$];
   logic [31:0] last_data = 32'd0;
   logic [15:0] lfsr_m = 16'hACE1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : model_cmp
      logic gate, bgo, e_wr, e_rd, beat_now, e_last;
      logic [31:0] lane;
      int idx, ln;
      cyc++;
`ifdef CACHE_RSP_STALL_EN
      gate = lfsr_m[0];
      bgo  = lfsr_m[1];
`else
      gate = 1'b1;
      bgo  = 1'b1;
`endif
      e_wr     = !reset && gate;
      e_rd     = e_wr && (busy == 0);
      beat_now = !reset && (busy != 0) && (wait_c == 0) && bgo;
      e_last   = beat_now && (beat_q.size() == 1);

      chk("rd_rdy", 32'(bus.rd_rdy), 32'(e_rd));
      chk("wr_rdy", 32'(bus.wr_rdy), 32'(e_wr));
      chk("ret_valid", 32'(bus.ret_valid), 32'(beat_now));
      chk("ret_last", 32'(bus.ret_last), 32'(e_last));
      if (beat_now && known[beat_q[0]]) chk("ret_data", bus.ret_data, mm[beat_q[0]]);
      if (reset) chk("ret_data_in_reset", bus.ret_data, 32'd0);

      if (bus.ret_valid) begin
         obs_q.push_back(bus.ret_data);
         if (lat_meas < 0) lat_meas = cyc - acc_cyc;
      end
      if (bus.ret_last) begin
         last_seen++;
         last_data = bus.ret_data;
      end

      // Advance the model to the state after the coming rising edge
      if (reset) begin
         busy   = 0;
         wait_c = 0;
         beat_q.delete();
         lfsr_m = 16'hACE1;
      end else begin
         if (beat_now) begin
            void'(beat_q.pop_front());
            if (beat_q.size() == 0) begin
               busy = 0;
               last_exp++;
            end
         end else if (busy != 0 && wait_c > 0) begin
            wait_c--;
         end
         if (bus.wr_req && e_wr) begin
            idx = int'(bus.wr_addr[MEM_AW+1:2]);
            if (bus.wr_type == 3'b100) begin
               for (int k = 0; k < 4; k++) begin
                  mm[(idx & ~3) + k]    = bus.wr_data[32*k +: 32];
                  known[(idx & ~3) + k] = 1'b1;
               end
            end else begin
               ln   = int'(bus.wr_addr[3:2]);
               lane = bus.wr_data[32*ln +: 32];
               for (int b = 0; b < 4; b++)
                  if (bus.wr_wstrb[b]) mm[idx][8*b +: 8] = lane[8*b +: 8];
               if (bus.wr_wstrb == 4'hF) known[idx] = 1'b1;
            end
         end
         if (bus.rd_req && e_rd) begin
            busy     = 1;
            wait_c   = RD_LAT - 1;
            acc_cyc  = cyc;
            lat_meas = -1;
            idx = int'(bus.rd_addr[MEM_AW+1:2]);
            if (bus.rd_type == 3'b100) begin
               for (int k = 0; k < 4; k++) beat_q.push_back((idx & ~3) + k);
            end else begin
               beat_q.push_back(idx);
            end
         end
         lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      end
   end

   task automatic idle_bus();
      bus.rd_req   = 1'b0;
      bus.rd_type  = 3'b000;
      bus.rd_addr  = 32'd0;
      bus.wr_req   = 1'b0;
      bus.wr_type  = 3'b000;
      bus.wr_addr  = 32'd0;
      bus.wr_wstrb = 4'h0;
      bus.wr_data  = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds the request(s) until the relevant rdy is seen, then drops them after the accepting edge
   task automatic issue(input bit do_rd, input logic [2:0] rt, input logic [31:0] ra,
                        input bit do_wr, input logic [2:0] wt, input logic [31:0] wa,
                        input logic [3:0] ws, input logic [127:0] wd);
      int n = 0;
      bus.rd_req   = do_rd;
      bus.rd_type  = rt;
      bus.rd_addr  = ra;
      bus.wr_req   = do_wr;
      bus.wr_type  = wt;
      bus.wr_addr  = wa;
      bus.wr_wstrb = ws;
      bus.wr_data  = wd;
      @(negedge clk);
      while (!(do_rd ? bus.rd_rdy : bus.wr_rdy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_fail++;
         $display("FAIL issue_timeout: rdy not seen within %0d cycles, required 1", n);
      end
      @(posedge clk);
      #1;
      idle_bus();
   endtask

   task automatic wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                     input logic [127:0] d);
      issue(1'b0, 3'b000, 32'd0, 1'b1, t, a, s, d);
   endtask

   task automatic rd(input logic [2:0] t, input logic [31:0] a);
      issue(1'b1, t, a, 1'b0, 3'b000, 32'd0, 4'h0, '0);
   endtask

   task automatic wait_last(input int l0);
      int n = 0;
      while (last_seen == l0 && n < 200) begin
         tick(1);
         n++;
      end
      if (last_seen == l0) begin
         n_fail++;
         $display("FAIL wait_last: ret_last seen 0 times within %0d cycles, required 1", n);
      end
      tick(1);
   endtask

   task automatic chk_beat(input string nm, input int k, input logic [31:0] exp);
      logic [31:0] act;
      act = (k < obs_q.size()) ? obs_q[k] : 32'hDEAD_BEEF;
      chk(nm, act, exp);
   endtask

   initial begin
      int l0, n;
      logic [31:0] ra;
      idle_bus();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;

      // Line write then line read with a non-zero offset inside the line
      wr(3'b100, 32'h0000_1000, 4'h0, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
      obs_q.delete();
      l0 = last_seen;
      rd(3'b100, 32'h0000_1008);
      wait_last(l0);
      chk("t1_beat_count", 32'(obs_q.size()), 32'd4);
      chk_beat("t1_beat0", 0, 32'hD0D0_0000);
      chk_beat("t1_beat1", 1, 32'hD1D1_0001);
      chk_beat("t1_beat2", 2, 32'hD2D2_0002);
      chk_beat("t1_beat3", 3, 32'hD3D3_0003);
      chk("t1_last_data", last_data, 32'hD3D3_0003);
      chk("t1_last_once", 32'(last_seen - l0), 32'd1);
`ifndef CACHE_RSP_STALL_EN
      chk("t1_latency", 32'(lat_meas), 32'(RD_LAT));
`endif

      // Byte-strobed word write into lane 1
      wr(3'b010, 32'h0000_2004, 4'hF, {32'h0, 32'h0, 32'hAABB_CCDD, 32'h0});
      wr(3'b010, 32'h0000_2004, 4'b0101, {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'h1122_3344, 32'h9999_9999});
      obs_q.delete();
      l0 = last_seen;
      rd(3'b010, 32'h0000_2004);
      wait_last(l0);
      chk("t2_beat_count", 32'(obs_q.size()), 32'd1);
      chk_beat("t2_merged", 0, 32'hAA22_CC44);
      chk("t2_last_data", last_data, 32'hAA22_CC44);

      // Zero strobe leaves the word untouched
      wr(3'b001, 32'h0000_2004, 4'h0, {4{32'h5555_5555}});
      obs_q.delete();
      l0 = last_seen;
      rd(3'b000, 32'h0000_2004);
      wait_last(l0);
      chk_beat("t2_wstrb0_noop", 0, 32'hAA22_CC44);

      // Read and write accepted together: the read sees the new line
      wr(3'b100, 32'h0000_3000, 4'h0, {4{32'h0BAD_0BAD}});
      obs_q.delete();
      l0 = last_seen;
      issue(1'b1, 3'b100, 32'h0000_3000, 1'b1, 3'b100, 32'h0000_3000, 4'h0,
            {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000});
      wait_last(l0);
      chk("t3_beat_count", 32'(obs_q.size()), 32'd4);
      chk_beat("t3_beat0", 0, 32'h3333_0000);
      chk_beat("t3_beat3", 3, 32'h3333_0003);

      // Reset in the middle of a line burst
      wr(3'b100, 32'h0000_5000, 4'h0, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000});
      obs_q.delete();
      l0 = last_seen;
      rd(3'b100, 32'h0000_5000);
      n = 0;
      while (obs_q.size() < 1 && n < 100) begin
         tick(1);
         n++;
      end
      chk("t4_first_beat_seen", 32'(obs_q.size() >= 1), 32'd1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      @(negedge clk);
      chk("t4_rd_rdy_after_reset", 32'(bus.rd_rdy), 32'd1);
      chk("t4_no_last", 32'(last_seen - l0), 32'd0);
      chk("t4_burst_cut", 32'(obs_q.size() < 4), 32'd1);
      @(posedge clk);
      #1;
      obs_q.delete();
      l0 = last_seen;
      rd(3'b100, 32'h0000_5000);
      wait_last(l0);
      chk_beat("t4_kept_beat0", 0, 32'h5555_0000);
      chk_beat("t4_kept_beat3", 3, 32'h5555_0003);

      // Address bits above the array alias onto the same words
      wr(3'b010, 32'h0000_0000, 4'hF, {32'h0, 32'h0, 32'h0, 32'h5A5A_A5A5});
      obs_q.delete();
      l0 = last_seen;
      rd(3'b010, 32'h1 << (MEM_AW + 2));
      wait_last(l0);
      chk_beat("t5_alias_hi", 0, 32'h5A5A_A5A5);
      wr(3'b111, (32'h1 << (MEM_AW + 2)) | 32'h4, 4'hF, {32'h0, 32'h0, 32'hC0DE_F00D, 32'h0});
      obs_q.delete();
      l0 = last_seen;
      rd(3'b011, 32'h0000_0004);
      wait_last(l0);
      chk_beat("t5_alias_lo", 0, 32'hC0DE_F00D);

      // Random traffic over a 64-line window with random aliasing upper bits
      for (int k = 0; k < 64; k++)
         wr(3'b100, 32'(k) << 4, 4'h0, {$urandom, $urandom, $urandom, $urandom});
      for (int c = 0; c < 2500; c++) begin
         ra = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 4) | 32'($urandom_range(0, 15));
         bus.rd_req   = ($urandom_range(0, 1) == 1);
         bus.rd_type  = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
         bus.rd_addr  = ra;
         bus.wr_req   = ($urandom_range(0, 9) < 4);
         bus.wr_type  = ($urandom_range(0, 3) == 0) ? 3'b100 : 3'($urandom_range(0, 7));
         bus.wr_addr  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 4) | 32'($urandom_range(0, 15));
         bus.wr_wstrb = 4'($urandom_range(0, 15));
         bus.wr_data  = {$urandom, $urandom, $urandom, $urandom};
         tick(1);
      end
      idle_bus();
      tick(40);
      chk("rand_last_count", 32'(last_seen), 32'(last_exp));
      chk("rand_idle_at_end", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
